cam_i2c_write_sequencer: RTL and testbench

Sequences camera register writes from the main control block onto the shared camera I2C byte interface.
- Accepts one command at a time: register address plus up to 8 payload bytes from the instruction/data buffer.
- Streams the address, then the payload, one byte per ready_for_next_byte handshake, framed by start and stop strobes.
- Enforces a per-byte timeout and NACK abort, then reports completion and error status back to the control block.

---
 rtl/cam_i2c_write_sequencer_if.sv | 31 +++
 rtl/cam_i2c_write_sequencer.sv | 153 +++++++++++++++
 tb/tb_cam_i2c_write_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_i2c_write_sequencer_if.sv
// Command and I2C byte-stream signals between the control block, the write
// sequencer and the camera I2C master.
interface cam_i2c_write_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  reg_addr;
    logic [63:0] reg_data;
    logic [3:0]  byte_count;
    logic        i2c_start;
    logic [7:0]  i2c_byte;
    logic        i2c_byte_valid;
    logic        ready_for_next_byte;
    logic        i2c_nack;
    logic        i2c_stop;
    logic        done;
    logic        error;
    logic        err_timeout;
    logic [3:0]  bytes_sent;

    modport slave (
        input  cmd_valid, reg_addr, reg_data, byte_count, ready_for_next_byte, i2c_nack,
        output cmd_ready, i2c_start, i2c_byte, i2c_byte_valid, i2c_stop,
               done, error, err_timeout, bytes_sent
    );

    modport master (
        output cmd_valid, reg_addr, reg_data, byte_count, ready_for_next_byte, i2c_nack,
        input  cmd_ready, i2c_start, i2c_byte, i2c_byte_valid, i2c_stop,
               done, error, err_timeout, bytes_sent
    );
endinterface

// File: rtl/cam_i2c_write_sequencer.sv
// Streams one camera register write (address + up to 8 bytes) onto the I2C byte
// interface with per-byte timeout and NACK abort. Optional retry: CAM_WR_RETRY_EN.
module cam_i2c_write_sequencer #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16,
    parameter int MAX_RETRIES    = 2
) (
    input  logic sysClk,
    input  logic sysRst_n,
    cam_i2c_write_sequencer_if.slave bus
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end
    if (MAX_RETRIES < 0) begin : g_bad_retries
        $error("MAX_RETRIES must not be negative");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_DONE, S_ERR
    } state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_addr;
    logic [63:0] r_data;
    logic [3:0]  r_n;
    logic [3:0]  r_bytes_sent;
    logic [CNT_W-1:0] r_cnt;
    logic        r_err;
    logic        r_err_timeout;

`ifdef CAM_WR_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    logic [RETRY_W-1:0] r_retry_cnt;
    logic w_retry;
    assign w_retry = r_err && (r_retry_cnt < RETRY_W'(MAX_RETRIES));
`endif

    logic       w_accept, w_presenting, w_nack, w_ack, w_tmo, w_last;
    logic [2:0] w_sel;

    assign w_accept     = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_presenting = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_nack       = w_presenting && bus.i2c_nack;
    assign w_ack        = w_presenting && bus.ready_for_next_byte && !bus.i2c_nack;
    // Terminal count is one short of TIMEOUT_CYCLES-1 so the byte is shown for exactly TIMEOUT_CYCLES-1 cycles.
    assign w_tmo        = w_presenting && !bus.ready_for_next_byte &&
                          (r_cnt == CNT_W'(TIMEOUT_CYCLES - 2));
    assign w_last       = (r_bytes_sent == r_n - 4'd1);
    // Payload goes out MSB-byte first: byte k of N lives at slot N-1-k.
    assign w_sel        = 3'(r_n - r_bytes_sent - 4'd1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_START;
            S_START: w_state_next = S_ADDR;
            S_ADDR: begin
                if (w_nack)      w_state_next = S_ERR;
                else if (w_ack)  w_state_next = (r_n == 4'd0) ? S_STOP : S_DATA;
                else if (w_tmo)  w_state_next = S_ERR;
            end
            S_DATA: begin
                if (w_nack)      w_state_next = S_ERR;
                else if (w_ack)  w_state_next = w_last ? S_STOP : S_DATA;
                else if (w_tmo)  w_state_next = S_ERR;
            end
            S_ERR:   w_state_next = S_STOP;
`ifdef CAM_WR_RETRY_EN
            S_STOP:  w_state_next = w_retry ? S_START : S_DONE;
`else
            S_STOP:  w_state_next = S_DONE;
`endif
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_data        <= '0;
            r_n           <= '0;
            r_bytes_sent  <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            r_err_timeout <= 1'b0;
`ifdef CAM_WR_RETRY_EN
            r_retry_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_addr        <= bus.reg_addr;
                r_data        <= bus.reg_data;
                r_n           <= (bus.byte_count > 4'd8) ? 4'd8 : bus.byte_count;
                r_bytes_sent  <= '0;
                r_err         <= 1'b0;
                r_err_timeout <= 1'b0;
`ifdef CAM_WR_RETRY_EN
                r_retry_cnt   <= '0;
`endif
            end

            if (r_state == S_START || w_ack)
                r_cnt <= '0;
            else if (w_presenting)
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_ack && r_state == S_DATA)
                r_bytes_sent <= r_bytes_sent + 4'd1;

            if (w_nack || w_tmo)
                r_err <= 1'b1;
            if (w_tmo && !w_nack)
                r_err_timeout <= 1'b1;

`ifdef CAM_WR_RETRY_EN
            // A new attempt starts clean; only the final attempt's status is reported.
            if (r_state == S_STOP && w_retry) begin
                r_retry_cnt   <= r_retry_cnt + RETRY_W'(1);
                r_err         <= 1'b0;
                r_err_timeout <= 1'b0;
                r_bytes_sent  <= '0;
            end
`endif
        end
    end

    always_comb begin
        bus.i2c_byte = 8'h00;
        if (r_state == S_ADDR)
            bus.i2c_byte = r_addr;
        else if (r_state == S_DATA)
            bus.i2c_byte = r_data[{w_sel, 3'b000} +: 8];
    end

    assign bus.cmd_ready      = (r_state == S_IDLE);
    assign bus.i2c_start      = (r_state == S_START);
    assign bus.i2c_byte_valid = w_presenting;
    assign bus.i2c_stop       = (r_state == S_STOP);
    assign bus.done           = (r_state == S_DONE);
    assign bus.error          = (r_state == S_DONE) && r_err;
    assign bus.err_timeout    = r_err_timeout;
    assign bus.bytes_sent     = r_bytes_sent;

endmodule

// File: tb/tb_cam_i2c_write_sequencer.sv
// Randomized scoreboard bench for cam_i2c_write_sequencer; the bench plays both the
// control block and the I2C master and predicts bytes, status and latency per command.
module tb_cam_i2c_write_sequencer;
    localparam int T           = 16;
    localparam int CNT_W       = 5;
    localparam int MAX_RETRIES = 2;
`ifdef CAM_WR_RETRY_EN
    localparam int MAX_ATTEMPTS = MAX_RETRIES + 1;
`else
    localparam int MAX_ATTEMPTS = 1;
`endif
    localparam int K_OK = 0, K_NACK = 1, K_TMO = 2;

    typedef struct { int kind; int dly; bit with_ack; } act_t;
    typedef struct { bit err; int sent; bit tmo; int starts; int lat; } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_i2c_write_sequencer_if bus();

    cam_i2c_write_sequencer #(
        .TIMEOUT_CYCLES(T), .CNT_W(CNT_W), .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .sysClk(clk), .sysRst_n(rst_n), .bus(bus)
    );

    act_t       act_q[$];
    logic [7:0] exp_byte_q[$];
    res_t       res_q[$];
    int  checks = 0, errors = 0;
    bit  rst_phase = 1'b0;
    int  cyc = 0, accept_cyc = 0;
    // monitor / responder state
    bit  pv = 1'b0, pa = 1'b0;
    int  n_starts = 0, n_stops = 0;
    res_t mres;
    logic [7:0] mbyte;
    act_t ract;
    int  tn = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic act_t pick(int mode, int att, int idx);
        act_t x;
        int   r;
        x.kind = K_OK; x.dly = 1; x.with_ack = 1'b0;
        case (mode)
            1: x.dly = 1;
            2: x.dly = 2;
            3: if (idx == 2) x.kind = K_TMO; else x.dly = $urandom_range(0, 3);
            4: if (idx == 1) begin x.kind = K_NACK; x.dly = 0; x.with_ack = 1'b1; end
            5: if (att < 2 && idx == 1) begin x.kind = K_NACK; x.dly = 1; end else x.dly = 0;
            6: if (idx == 0) begin x.kind = K_NACK; x.dly = 2; end
            default: begin
                r = $urandom_range(0, 31);
                if (r < 2) begin
                    x.kind = K_NACK; x.dly = $urandom_range(0, 4); x.with_ack = 1'($urandom);
                end else if (r == 2) x.kind = K_TMO;
                else if (r < 6) x.dly = T - 2;
                else x.dly = $urandom_range(0, 3);
            end
        endcase
        return x;
    endfunction

    // Reference model: expands a command into presented bytes, responder actions and the final status.
    task automatic plan_cmd(logic [7:0] a, logic [63:0] d, logic [3:0] c, int mode);
        logic [7:0] seq[$];
        res_t r;
        act_t x;
        int   n, sent;
        bit   fail, tmo;
        n = (c > 4'd8) ? 8 : int'(c);
        seq.push_back(a);
        for (int k = 0; k < n; k++) seq.push_back(8'(d >> (8 * (n - 1 - k))));
        r.starts = 0; r.lat = 1; r.err = 1'b0; r.sent = 0; r.tmo = 1'b0;
        for (int att = 0; att < MAX_ATTEMPTS; att++) begin
            fail = 1'b0; tmo = 1'b0; sent = 0;
            r.starts++;
            r.lat += 2;
            for (int i = 0; i <= n; i++) begin
                x = pick(mode, att, i);
                exp_byte_q.push_back(seq[i]);
                act_q.push_back(x);
                if (x.kind == K_OK) begin
                    r.lat += x.dly + 1;
                    if (i > 0) sent++;
                end else if (x.kind == K_NACK) begin
                    r.lat += x.dly + 2; fail = 1'b1; break;
                end else begin
                    r.lat += T; fail = 1'b1; tmo = 1'b1; break;
                end
            end
            r.err = fail; r.sent = sent; r.tmo = tmo;
            if (!fail) break;
        end
        res_q.push_back(r);
    endtask

    task automatic issue(logic [7:0] a, logic [63:0] d, logic [3:0] c, int mode, bit hold);
        int w;
        w = 0;
        bus.cmd_valid = 1'b1; bus.reg_addr = a; bus.reg_data = d; bus.byte_count = c;
        while (!bus.cmd_ready && w < 3000) begin @(negedge clk); w++; end
        if (!bus.cmd_ready) begin
            chk("cmd_ready_wait", 64'(bus.cmd_ready), 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        plan_cmd(a, d, c, mode);
        @(negedge clk);
        bus.reg_addr = 8'($urandom); bus.reg_data = {$urandom, $urandom};
        bus.byte_count = 4'($urandom);
        bus.cmd_valid = hold;
    endtask

    // I2C master model: acks, NACKs or stalls each presented byte as planned.
    initial begin
        bus.ready_for_next_byte = 1'b0; bus.i2c_nack = 1'b0;
        @(negedge clk);
        forever begin
            if (bus.i2c_byte_valid && !rst_phase) begin
                if (act_q.size() == 0) begin
                    chk("responder_plan", 64'(act_q.size()), 1);
                    @(negedge clk);
                end else begin
                    ract = act_q.pop_front();
                    if (ract.kind == K_TMO) begin
                        tn = 0;
                        while (bus.i2c_byte_valid && tn < T + 4) begin tn++; @(negedge clk); end
                        chk("timeout_len", 64'(tn), T - 1);
                    end else begin
                        repeat (ract.dly) @(negedge clk);
                        if (ract.kind == K_NACK) begin
                            bus.i2c_nack = 1'b1; bus.ready_for_next_byte = ract.with_ack;
                        end else bus.ready_for_next_byte = 1'b1;
                        @(negedge clk);
                        bus.ready_for_next_byte = 1'b0; bus.i2c_nack = 1'b0;
                    end
                end
            end else @(negedge clk);
        end
    end

    // Monitor: compares presented bytes and completion status against the scoreboard.
    initial begin
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (!rst_n) begin
                pv = 1'b0; pa = 1'b0;
            end else begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    accept_cyc = cyc; n_starts = 0; n_stops = 0;
                end
                if (bus.i2c_start) n_starts++;
                if (bus.i2c_stop)  n_stops++;
                if (bus.i2c_byte_valid && (!pv || pa) && !rst_phase) begin
                    if (exp_byte_q.size() == 0) chk("byte_expected", 0, 1);
                    else begin
                        mbyte = exp_byte_q.pop_front();
                        chk("i2c_byte", 64'(bus.i2c_byte), 64'(mbyte));
                    end
                end
                if (bus.error) chk("error_implies_done", 64'(bus.done), 1);
                if (bus.done) begin
                    if (res_q.size() == 0) chk("done_expected", 0, 1);
                    else begin
                        mres = res_q.pop_front();
                        chk("error",       64'(bus.error), 64'(mres.err));
                        chk("bytes_sent",  64'(bus.bytes_sent), 64'(mres.sent));
                        chk("err_timeout", 64'(bus.err_timeout), 64'(mres.tmo));
                        chk("start_count", 64'(n_starts), 64'(mres.starts));
                        chk("stop_count",  64'(n_stops), 64'(mres.starts));
                        chk("done_latency", 64'(cyc - accept_cyc), 64'(mres.lat));
                        $display("txn done: error=%0d bytes_sent=%0d err_timeout=%0d starts=%0d latency=%0d",
                                 bus.error, bus.bytes_sent, bus.err_timeout, n_starts, cyc - accept_cyc);
                    end
                end
                pv = bus.i2c_byte_valid;
                pa = bus.ready_for_next_byte;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_cmd_ready"},   64'(bus.cmd_ready), 1);
        chk({tag, "_i2c_start"},   64'(bus.i2c_start), 0);
        chk({tag, "_i2c_byte"},    64'(bus.i2c_byte), 0);
        chk({tag, "_byte_valid"},  64'(bus.i2c_byte_valid), 0);
        chk({tag, "_i2c_stop"},    64'(bus.i2c_stop), 0);
        chk({tag, "_done"},        64'(bus.done), 0);
        chk({tag, "_error"},       64'(bus.error), 0);
        chk({tag, "_err_timeout"}, 64'(bus.err_timeout), 0);
        chk({tag, "_bytes_sent"},  64'(bus.bytes_sent), 0);
    endtask

    initial begin
        int w;
        bit hold;
        bus.cmd_valid = 1'b0; bus.reg_addr = '0; bus.reg_data = '0; bus.byte_count = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h3A, {$urandom, $urandom}, 4'd0, 1, 1'b0);
        issue(8'h12, 64'hFFEE_DDCC_00A1_B2C3, 4'd3, 2, 1'b0);
        issue(8'($urandom), 64'h0102_0304_0506_0708, 4'd12, 1, 1'b0);
        issue(8'($urandom), {$urandom, $urandom}, 4'd3, 3, 1'b0);
        issue(8'($urandom), {$urandom, $urandom}, 4'd2, 4, 1'b1);
        issue(8'($urandom), {$urandom, $urandom}, 4'd1, 5, 1'b0);
        issue(8'($urandom), {$urandom, $urandom}, 4'd2, 6, 1'b0);
        for (int k = 0; k < 60; k++) begin
            hold = 1'($urandom);
            issue(8'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 15)), 0, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.cmd_valid = 1'b0;

        w = 0;
        while ((res_q.size() != 0 || !bus.cmd_ready) && w < 5000) begin @(negedge clk); w++; end
        chk("drain_results", 64'(res_q.size()), 0);
        chk("drain_actions", 64'(act_q.size()), 0);
        chk("drain_bytes",   64'(exp_byte_q.size()), 0);

        // Reset in the middle of the payload.
        rst_phase = 1'b1;
        bus.cmd_valid = 1'b1; bus.reg_addr = 8'h55;
        bus.reg_data = 64'h1122_3344_5566_7788; bus.byte_count = 4'd8;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_ph_addr", 64'(bus.i2c_byte), 64'h55);
        bus.ready_for_next_byte = 1'b1; @(negedge clk); bus.ready_for_next_byte = 1'b0;
        chk("rst_ph_byte0", 64'(bus.i2c_byte), 64'h11);
        bus.ready_for_next_byte = 1'b1; @(negedge clk); bus.ready_for_next_byte = 1'b0;
        chk("rst_ph_byte1", 64'(bus.i2c_byte), 64'h22);
        chk("rst_ph_sent",  64'(bus.bytes_sent), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_stop", 64'(bus.i2c_stop), 0);
        chk("post_reset_ready", 64'(bus.cmd_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
